fp_mul_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier for the ALU datapath.
- Successor to the combinational single-precision multiplier: operand format set by EXP_W/FRC_W; adds a valid/ready handshake with backpressure.
- Retains the flush-to-zero contract: any operand with a zero exponent field multiplies as signed zero.
- Adds five rounding modes, canonical NaN generation and registered overflow/underflow flags.

---
 rtl/fp_pkg.sv | 49 ++++
 rtl/fp_round.sv | 55 +++++
 rtl/fp_mul_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared types and helpers for the pipelined FP multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rmode_e;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    // Exponent bias for an ew-bit exponent field.
    function automatic int bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Quiet NaN: sign 0, exponent all ones, fraction MSB set. Caller truncates.
    function automatic logic [127:0] canonical_nan(input int ew, input int fw);
        logic [127:0] v;
        v = ((128'd1 << ew) - 128'd1) << fw;
        v = v | (128'd1 << (fw - 1));
        return v;
    endfunction

    // Operand class; a zero exponent flushes regardless of fraction.
    function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic frc_nz);
        if (exp_zero)
            return ZERO;
        else if (exp_ones)
            return frc_nz ? NAN : INF;
        else
            return NORM;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_round
// Description : Combinational rounding of a normalised significand; reports
//               carry into the exponent and post-rounding overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                      i_sign,
    input  logic [FRC_W-1:0]          i_frac,
    input  logic                      i_guard,
    input  logic                      i_round,
    input  logic                      i_sticky,
    input  logic signed [EXP_W+1:0]   i_exp,
    input  rmode_e                    i_mode,
    output logic [FRC_W-1:0]          o_frac,
    output logic                      o_carry,
    output logic                      o_ovrf
);

    localparam logic signed [EXP_W+1:0] c_exp_ones = {2'b00, {EXP_W{1'b1}}};

    logic                    w_inexact;
    logic                    w_inc;
    logic [FRC_W:0]          w_sum;
    logic signed [EXP_W+1:0] w_exp_post;

    assign w_inexact = i_guard | i_round | i_sticky;

    // Decide whether the discarded bits push the fraction up one ulp.
    always_comb begin
        w_inc = 1'b0;
        case (i_mode)
            RNE:     w_inc = i_guard & (i_round | i_sticky | i_frac[0]);
            RTZ:     w_inc = 1'b0;
            RDN:     w_inc = w_inexact & i_sign;
            RUP:     w_inc = w_inexact & ~i_sign;
            RMM:     w_inc = i_guard;
            default: w_inc = 1'b0;
        endcase
    end

    assign w_sum      = {1'b0, i_frac} + {{FRC_W{1'b0}}, w_inc};
    assign o_frac     = w_sum[FRC_W-1:0];
    assign o_carry    = w_sum[FRC_W];
    assign w_exp_post = i_exp + $signed({{(EXP_W+1){1'b0}}, o_carry});
    assign o_ovrf     = (w_exp_post >= c_exp_ones);

endmodule
`default_nettype wire

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_pipe
// Description : 3-stage pipelined floating-point multiplier with valid/ready
//               handshake, global stall, five rounding modes and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRC_W:0]   fp_X,
    input  logic [EXP_W+FRC_W:0]   fp_Y,
    input  logic [2:0]             r_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+FRC_W:0]   fp_Z,
    output logic                   ovrf,
    output logic                   udrf
);

    localparam int c_w  = 1 + EXP_W + FRC_W;
    localparam int c_pw = 2 * FRC_W + 2;
    localparam int c_xw = EXP_W + 2;
    localparam logic [EXP_W-1:0]      c_exp_ones = {EXP_W{1'b1}};
    localparam logic signed [c_xw-1:0] c_bias    = c_xw'(bias(EXP_W));
    localparam logic [c_w-1:0]        c_nan      = c_w'(canonical_nan(EXP_W, FRC_W));

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ---------------- S1: unpack / classify / multiply ----------------
    fp_class_e               w_cx, w_cy, w_cls;
    logic [c_pw-1:0]         w_prod;
    logic signed [c_xw-1:0]  w_esum;
    rmode_e                  w_mode;

    assign w_cx = classify(fp_X[c_w-2:FRC_W] == '0, fp_X[c_w-2:FRC_W] == c_exp_ones,
                           |fp_X[FRC_W-1:0]);
    assign w_cy = classify(fp_Y[c_w-2:FRC_W] == '0, fp_Y[c_w-2:FRC_W] == c_exp_ones,
                           |fp_Y[FRC_W-1:0]);

    // Resolve the special-case priority into one result class.
    always_comb begin
        w_cls = NORM;
        if (w_cx == NAN || w_cy == NAN || (w_cx == INF && w_cy == ZERO) ||
            (w_cx == ZERO && w_cy == INF))
            w_cls = NAN;
        else if (w_cx == INF || w_cy == INF)
            w_cls = INF;
        else if (w_cx == ZERO || w_cy == ZERO)
            w_cls = ZERO;
    end

    assign w_prod = {{(FRC_W+1){1'b0}}, 1'b1, fp_X[FRC_W-1:0]} *
                    {{(FRC_W+1){1'b0}}, 1'b1, fp_Y[FRC_W-1:0]};
    assign w_esum = $signed({2'b00, fp_X[c_w-2:FRC_W]}) +
                    $signed({2'b00, fp_Y[c_w-2:FRC_W]}) - c_bias;
    assign w_mode = (r_mode > 3'd4) ? RNE : rmode_e'(r_mode);

    logic                   r_s1_valid, r_s1_sign;
    fp_class_e              r_s1_cls;
    logic [c_pw-1:0]        r_s1_prod;
    logic signed [c_xw-1:0] r_s1_exp;
    rmode_e                 r_s1_mode;

    // Stage 1 register: capture operands on a transfer, bubble otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_cls   <= ZERO;
            r_s1_prod  <= '0;
            r_s1_exp   <= '0;
            r_s1_mode  <= RNE;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= fp_X[c_w-1] ^ fp_Y[c_w-1];
            r_s1_cls   <= w_cls;
            r_s1_prod  <= w_prod;
            r_s1_exp   <= w_esum;
            r_s1_mode  <= w_mode;
        end
    end

    // ---------------- S2: normalise ----------------
    logic [FRC_W-1:0]       w_frac;
    logic                   w_g, w_r, w_s;
    logic signed [c_xw-1:0] w_nexp;

    // Product lies in [1,4); a set MSB means one extra right shift.
    always_comb begin
        w_frac = r_s1_prod[2*FRC_W-1:FRC_W];
        w_g    = r_s1_prod[FRC_W-1];
        w_r    = r_s1_prod[FRC_W-2];
        w_s    = |r_s1_prod[FRC_W-3:0];
        w_nexp = r_s1_exp;
        if (r_s1_prod[c_pw-1]) begin
            w_frac = r_s1_prod[2*FRC_W:FRC_W+1];
            w_g    = r_s1_prod[FRC_W];
            w_r    = r_s1_prod[FRC_W-1];
            w_s    = |r_s1_prod[FRC_W-2:0];
            w_nexp = r_s1_exp + $signed({{(c_xw-1){1'b0}}, 1'b1});
        end
    end

    logic                   r_s2_valid, r_s2_sign, r_s2_g, r_s2_r, r_s2_s;
    fp_class_e              r_s2_cls;
    logic [FRC_W-1:0]       r_s2_frac;
    logic signed [c_xw-1:0] r_s2_exp;
    rmode_e                 r_s2_mode;

    // Stage 2 register: normalised significand plus rounding bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_cls   <= ZERO;
            r_s2_frac  <= '0;
            r_s2_g     <= 1'b0;
            r_s2_r     <= 1'b0;
            r_s2_s     <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_mode  <= RNE;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_cls   <= r_s1_cls;
            r_s2_frac  <= w_frac;
            r_s2_g     <= w_g;
            r_s2_r     <= w_r;
            r_s2_s     <= w_s;
            r_s2_exp   <= w_nexp;
            r_s2_mode  <= r_s1_mode;
        end
    end

    // ---------------- S3: round / pack / flags ----------------
    logic [FRC_W-1:0]       w_rfrac;
    logic                   w_carry, w_rovf, w_udf, w_inf_ok;
    logic signed [c_xw-1:0] w_exp_post;
    logic [c_w-1:0]         w_z;
    logic                   w_of, w_uf;

    fp_round #(
        .EXP_W (EXP_W),
        .FRC_W (FRC_W)
    ) u_round (
        .i_sign   (r_s2_sign),
        .i_frac   (r_s2_frac),
        .i_guard  (r_s2_g),
        .i_round  (r_s2_r),
        .i_sticky (r_s2_s),
        .i_exp    (r_s2_exp),
        .i_mode   (r_s2_mode),
        .o_frac   (w_rfrac),
        .o_carry  (w_carry),
        .o_ovrf   (w_rovf)
    );

    assign w_exp_post = r_s2_exp + $signed({{(c_xw-1){1'b0}}, w_carry});
    assign w_udf      = r_s2_exp[c_xw-1] || (r_s2_exp == '0);
    assign w_inf_ok   = (r_s2_mode == RNE) || (r_s2_mode == RMM) ||
                        (r_s2_mode == RUP && !r_s2_sign) || (r_s2_mode == RDN && r_s2_sign);

    // Pack the result; underflow is checked first so the flags never coexist.
    always_comb begin
        w_z  = {r_s2_sign, w_exp_post[EXP_W-1:0], w_rfrac};
        w_of = 1'b0;
        w_uf = 1'b0;
        case (r_s2_cls)
            NAN:  w_z = c_nan;
            INF:  w_z = {r_s2_sign, c_exp_ones, {FRC_W{1'b0}}};
            ZERO: w_z = {r_s2_sign, {(c_w-1){1'b0}}};
            default: begin
                if (w_udf) begin
                    w_uf = 1'b1;
                    w_z  = {r_s2_sign, {(c_w-1){1'b0}}};
                end else if (w_rovf) begin
                    w_of = 1'b1;
                    w_z  = w_inf_ok ? {r_s2_sign, c_exp_ones, {FRC_W{1'b0}}}
                                    : {r_s2_sign, c_exp_ones - 1'b1, {FRC_W{1'b1}}};
                end
            end
        endcase
    end

    // Output register: holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            fp_Z      <= '0;
            ovrf      <= 1'b0;
            udrf      <= 1'b0;
        end else if (w_adv) begin
            out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                fp_Z <= w_z;
                ovrf <= w_of;
                udrf <= w_uf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_pipe
// Description : Self-checking bench for fp_mul_pipe (single precision).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fp_X = '0;
    logic [31:0] fp_Y = '0;
    logic [2:0]  r_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] z;
        logic        ov;
        logic        uf;
    } res_t;

    res_t exp_q[$];

    fp_mul_pipe #(.EXP_W(8), .FRC_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .r_mode    (r_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the discarded
    // remainder against one half ulp.
    function automatic res_t ref_mul(input logic [31:0] x, input logic [31:0] y,
                                     input logic [2:0] mode);
        res_t r;
        logic s;
        int ex, ey, e, k, sh;
        longint unsigned m, q, rem, half;
        bit up, inexact, xz, yz, xi, yi, xn, yn, inf_ok;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);  yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);  yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);  yn = (ey == 255) && (y[22:0] != 0);
        r.ov = 1'b0;
        r.uf = 1'b0;
        if (xn || yn || (xi && yz) || (xz && yi))
            r.z = 32'h7FC00000;
        else if (xi || yi)
            r.z = {s, 8'hFF, 23'h0};
        else if (xz || yz)
            r.z = {s, 31'h0};
        else begin
            m = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
            k = 63;
            while (((m >> k) & 64'd1) == 64'd0) k--;
            e = ex + ey - 127 + (k - 46);
            if (e <= 0) begin
                r.uf = 1'b1;
                r.z  = {s, 31'h0};
            end else begin
                sh      = k - 23;
                q       = m >> sh;
                rem     = m - (q << sh);
                half    = 64'd1 << (sh - 1);
                inexact = (rem != 0);
                case (mode)
                    3'd1:    up = 1'b0;
                    3'd2:    up = inexact && s;
                    3'd3:    up = inexact && !s;
                    3'd4:    up = (rem >= half);
                    default: up = (rem > half) || (rem == half && q[0]);
                endcase
                q = q + 64'(up);
                if (q == (64'd1 << 24)) begin
                    q = q >> 1;
                    e++;
                end
                if (e >= 255) begin
                    inf_ok = (mode == 3'd0) || (mode >= 3'd4) || (mode == 3'd3 && !s) ||
                             (mode == 3'd2 && s);
                    r.ov = 1'b1;
                    r.z  = inf_ok ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
                end else
                    r.z = {s, 8'(e), q[22:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        case ($urandom_range(0, 15))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(1, 12));
            4, 5:    e = 8'($urandom_range(240, 254));
            default: e = 8'($urandom_range(90, 165));
        endcase
        return {1'(($urandom >> 7) & 1), e, 23'($urandom)};
    endfunction

    // Present one operand pair and wait (bounded) for it to be accepted.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                         input res_t e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        fp_X     = x;
        fp_Y     = y;
        r_mode   = m;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL issue_timeout: observed in_ready=0 for 50 cycles expected acceptance");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every transferred result is compared in order.
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_result: observed fp_Z=%h with nothing outstanding expected none",
                       fp_Z);
            end
            if (exp_q.size() != 0)
                chk("result", 64'({fp_Z, ovrf, udrf}), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [31:0] held;
        logic [31:0] rx, ry;
        logic [2:0]  rm;
        bit          pend;
        int          acc;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", 64'({out_valid, fp_Z, ovrf, udrf}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Basic product and latency
        issue(32'h3FC00000, 32'h40000000, 3'd0, {32'h40400000, 1'b0, 1'b0});
        in_valid = 1'b0;
        #1 chk("latency_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1 chk("latency_c2", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1 chk("latency_c3", 64'({out_valid, fp_Z}), {31'd0, 1'b1, 32'h40400000});
        idle(3);

        // Rounding modes, back to back
        issue(32'h3F800001, 32'h3F800001, 3'd0, {32'h3F800002, 1'b0, 1'b0});
        issue(32'h3F800001, 32'h3F800001, 3'd1, {32'h3F800002, 1'b0, 1'b0});
        issue(32'h3F800001, 32'h3F800001, 3'd3, {32'h3F800003, 1'b0, 1'b0});
        issue(32'h3F800001, 32'h3F800001, 3'd6, {32'h3F800002, 1'b0, 1'b0});
        // Flush and underflow
        issue(32'h80000001, 32'h3F800000, 3'd0, {32'h80000000, 1'b0, 1'b0});
        issue(32'h00800000, 32'h3F000000, 3'd0, {32'h00000000, 1'b0, 1'b1});
        // Overflow and specials
        issue(32'h7F000000, 32'h7F000000, 3'd0, {32'h7F800000, 1'b1, 1'b0});
        issue(32'h7F000000, 32'h7F000000, 3'd1, {32'h7F7FFFFF, 1'b1, 1'b0});
        issue(32'hFF000000, 32'h7F000000, 3'd3, {32'hFF7FFFFF, 1'b1, 1'b0});
        issue(32'hFF000000, 32'h7F000000, 3'd2, {32'hFF800000, 1'b1, 1'b0});
        issue(32'h7F800000, 32'h00000000, 3'd0, {32'h7FC00000, 1'b0, 1'b0});
        issue(32'hFF800000, 32'h40000000, 3'd0, {32'hFF800000, 1'b0, 1'b0});
        issue(32'h7F800001, 32'h3F800000, 3'd0, {32'h7FC00000, 1'b0, 1'b0});
        idle(6);
        chk("directed_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: stall with a result waiting and a new operand offered
        for (int i = 0; i < 4; i++) begin
            rx = 32'h3F800000 + 32'(i * 32'h00123457);
            ry = 32'h40100000 + 32'(i * 32'h00010001);
            issue(rx, ry, 3'd0, ref_mul(rx, ry, 3'd0));
        end
        fp_X      = 32'h40A00000;
        fp_Y      = 32'h40A00000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1 held = fp_Z;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_hold", 64'(fp_Z), 64'(held));
            @(negedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(6);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with operations in flight
        issue(32'h40400000, 32'h40400000, 3'd0, {32'h41100000, 1'b0, 1'b0});
        issue(32'h40400000, 32'h40000000, 3'd0, {32'h40C00000, 1'b0, 1'b0});
        issue(32'h40000000, 32'h40000000, 3'd0, {32'h40800000, 1'b0, 1'b0});
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_outputs", 64'({out_valid, fp_Z, ovrf, udrf}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("midrst_no_stale", 64'(out_valid), 64'd0);
            @(negedge clk);
        end

        // Randomised traffic with random backpressure against the model
        acc  = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 4000 && acc < 250; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend && $urandom_range(0, 3) != 0) begin
                rx   = rand_op();
                ry   = rand_op();
                rm   = 3'($urandom_range(0, 7));
                pend = 1'b1;
            end
            in_valid = pend;
            fp_X     = rx;
            fp_Y     = ry;
            r_mode   = rm;
            #1;
            if (pend && in_ready) begin
                exp_q.push_back(ref_mul(rx, ry, rm));
                pend = 1'b0;
                acc++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("random_accepted", 64'(acc), 64'd250);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
